// File: rtl/dbus_pkg.sv
// Shared types and helpers for the data-bus controller.
package dbus_pkg;

  localparam int IO_AW = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAM_RD  = 2'd1,
    ST_IO_WAIT = 2'd2,
    ST_IO_RESP = 2'd3
  } dbus_state_e;

  // Bit 31 selects the peripheral bus; everything below is SRAM (aliased).
  function automatic logic is_io(input logic [31:0] addr);
    return addr[31];
  endfunction

endpackage

// File: rtl/dbus_ctrl.sv
// Data-bus controller: routes core loads/stores to the data SRAM or to the
// peripheral bus (with wait states and a timeout), and generates the
// core-side ready strobes and read data.
module dbus_ctrl
  import dbus_pkg::*;
#(
  parameter int          RAM_AW     = 12,
  parameter int          IO_TIMEOUT = 16,
  parameter logic [31:0] ERR_RDATA  = 32'h0
) (
  input  logic              clk,
  input  logic              rstb,
  // core side
  input  logic [31:0]       d_addr,
  input  logic              d_rd_req,
  input  logic              d_wr_req,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_wr_data,
  output logic              d_rd_ready,
  output logic              d_wr_ready,
  output logic [31:0]       d_rd_data,
  // data SRAM
  output logic              ram_cs,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  // peripheral bus
  output logic              io_req,
  output logic              io_we,
  output logic [IO_AW-1:0]  io_addr,
  output logic [3:0]        io_be,
  output logic [31:0]       io_wdata,
  input  logic              io_ack,
  input  logic [31:0]       io_rdata,
  // timeout reporting
  output logic              err_valid,
  output logic [31:0]       err_addr
);

  localparam int CW = (IO_TIMEOUT > 2) ? $clog2(IO_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(IO_TIMEOUT - 1);

  dbus_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          io_req_q, io_req_d;
  logic          io_we_q, io_we_d;
  logic [3:0]    io_be_q, io_be_d;
  logic [31:0]   io_wdata_q, io_wdata_d;
  logic [31:0]   addr_q, addr_d;     // full address of the IO access, for err_addr
  logic [31:0]   rdata_q, rdata_d;   // captured peripheral read data
  logic          err_valid_q, err_valid_d;
  logic [31:0]   err_addr_q, err_addr_d;

  assign io_req    = io_req_q;
  assign io_we     = io_we_q;
  assign io_addr   = addr_q[IO_AW-1:0];
  assign io_be     = io_be_q;
  assign io_wdata  = io_wdata_q;
  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;

  // State and registered peripheral/error fields.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      io_req_q    <= 1'b0;
      io_we_q     <= 1'b0;
      io_be_q     <= '0;
      io_wdata_q  <= '0;
      addr_q      <= '0;
      rdata_q     <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      io_req_q    <= io_req_d;
      io_we_q     <= io_we_d;
      io_be_q     <= io_be_d;
      io_wdata_q  <= io_wdata_d;
      addr_q      <= addr_d;
      rdata_q     <= rdata_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Next-state logic plus the combinational SRAM strobes and core responses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    io_req_d    = io_req_q;
    io_we_d     = io_we_q;
    io_be_d     = io_be_q;
    io_wdata_d  = io_wdata_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    err_valid_d = 1'b0;
    err_addr_d  = err_addr_q;
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_be      = '0;
    ram_addr    = '0;
    ram_wdata   = '0;
    d_rd_ready  = 1'b0;
    d_wr_ready  = 1'b0;
    d_rd_data   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (d_rd_req || d_wr_req) begin
          if (is_io(d_addr)) begin
            // Read wins when both are pending; the write is a later access.
            io_req_d   = 1'b1;
            io_we_d    = ~d_rd_req;
            addr_d     = d_addr;
            io_be_d    = d_be;
            io_wdata_d = d_wr_data;
            cnt_d      = '0;
            state_d    = ST_IO_WAIT;
          end else if (d_rd_req) begin
            ram_cs   = 1'b1;
            ram_addr = d_addr[RAM_AW+1:2];
            state_d  = ST_RAM_RD;
          end else begin
            // Zero-wait store: the SRAM write and the ready share a cycle.
            ram_cs     = 1'b1;
            ram_we     = 1'b1;
            ram_be     = d_be;
            ram_addr   = d_addr[RAM_AW+1:2];
            ram_wdata  = d_wr_data;
            d_wr_ready = 1'b1;
          end
        end
      end
      ST_RAM_RD: begin
        d_rd_ready = 1'b1;
        d_rd_data  = ram_rdata;
        state_d    = ST_IDLE;
      end
      ST_IO_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // An ack on the last allowed cycle still counts as success.
        if (io_ack) begin
          rdata_d  = io_rdata;
          io_req_d = 1'b0;
          state_d  = ST_IO_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d     = ERR_RDATA;
          io_req_d    = 1'b0;
          err_valid_d = 1'b1;
          err_addr_d  = addr_q;
          state_d     = ST_IO_RESP;
        end
      end
      ST_IO_RESP: begin
        if (io_we_q) begin
          d_wr_ready = 1'b1;
        end else begin
          d_rd_ready = 1'b1;
          d_rd_data  = rdata_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Keep every combinational output quiet while reset is held.
    if (!rstb) begin
      ram_cs     = 1'b0;
      ram_we     = 1'b0;
      ram_be     = '0;
      ram_addr   = '0;
      ram_wdata  = '0;
      d_rd_ready = 1'b0;
      d_wr_ready = 1'b0;
      d_rd_data  = '0;
    end
  end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed bench for dbus_ctrl: RAM and IO paths, timeout, arbitration, reset.
module tb_dbus_ctrl;

  logic        clk = 1'b0;
  logic        rstb;
  logic [31:0] d_addr;
  logic        d_rd_req, d_wr_req;
  logic [3:0]  d_be;
  logic [31:0] d_wr_data;
  logic        d_rd_ready, d_wr_ready;
  logic [31:0] d_rd_data;
  logic        ram_cs, ram_we;
  logic [3:0]  ram_be;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        io_req, io_we;
  logic [15:0] io_addr;
  logic [3:0]  io_be;
  logic [31:0] io_wdata;
  logic        io_ack;
  logic [31:0] io_rdata;
  logic        err_valid;
  logic [31:0] err_addr;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  dbus_ctrl #(.RAM_AW(12), .IO_TIMEOUT(16), .ERR_RDATA(32'h0)) dut (
    .clk(clk), .rstb(rstb),
    .d_addr(d_addr), .d_rd_req(d_rd_req), .d_wr_req(d_wr_req),
    .d_be(d_be), .d_wr_data(d_wr_data),
    .d_rd_ready(d_rd_ready), .d_wr_ready(d_wr_ready), .d_rd_data(d_rd_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_be(io_be),
    .io_wdata(io_wdata), .io_ack(io_ack), .io_rdata(io_rdata),
    .err_valid(err_valid), .err_addr(err_addr)
  );

  // Synchronous SRAM model with byte enables, one-cycle read latency.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rstb = 1'b0; d_addr = '0; d_rd_req = 1'b0; d_wr_req = 1'b0;
    d_be = '0; d_wr_data = '0; io_ack = 1'b0; io_rdata = '0;
    tick(); tick();
    // reset state
    chk("rst_io_req", {31'b0, io_req}, 32'h0);
    chk("rst_rd_ready", {31'b0, d_rd_ready}, 32'h0);
    chk("rst_wr_ready", {31'b0, d_wr_ready}, 32'h0);
    chk("rst_rd_data", d_rd_data, 32'h0);
    chk("rst_ram_cs", {31'b0, ram_cs}, 32'h0);
    chk("rst_err_valid", {31'b0, err_valid}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_io_addr", {16'h0, io_addr}, 32'h0);
    rstb = 1'b1;
    tick();

    // RAM write, zero wait
    d_addr = 32'h100; d_be = 4'h4; d_wr_data = 32'h00AB0000; d_wr_req = 1'b1;
    #1;
    chk("wr_ready", {31'b0, d_wr_ready}, 32'h1);
    chk("wr_cs_we", {30'b0, ram_cs, ram_we}, 32'h3);
    chk("wr_ram_addr", {20'h0, ram_addr}, 32'h40);
    chk("wr_ram_be", {28'h0, ram_be}, 32'h4);
    chk("wr_ram_wdata", ram_wdata, 32'h00AB0000);
    tick();
    d_wr_req = 1'b0;

    // RAM read back, one wait state
    d_rd_req = 1'b1;
    #1;
    chk("rd_req_cs_we", {30'b0, ram_cs, ram_we}, 32'h2);
    chk("rd_ram_addr", {20'h0, ram_addr}, 32'h40);
    chk("rd_not_ready_n", {31'b0, d_rd_ready}, 32'h0);
    tick();
    chk("rd_ready_n1", {31'b0, d_rd_ready}, 32'h1);
    chk("rd_data", d_rd_data, 32'h00AB0000);
    d_rd_req = 1'b0;
    tick();
    chk("rd_data_idle_zero", d_rd_data, 32'h0);

    // Aliasing: bits above the RAM index are ignored
    d_addr = 32'h0000_4100; d_wr_req = 1'b1; d_be = 4'hF;
    #1;
    chk("alias_ram_addr", {20'h0, ram_addr}, 32'h40);

    // Back-to-back stores, one per cycle (preload words 0..2)
    d_addr = 32'h0; d_wr_data = 32'h1111_1111;
    #1; chk("st0_ready", {31'b0, d_wr_ready}, 32'h1);
    tick();
    d_addr = 32'h4; d_wr_data = 32'h2222_2222;
    #1; chk("st1_ready", {31'b0, d_wr_ready}, 32'h1);
    chk("st1_ram_addr", {20'h0, ram_addr}, 32'h1);
    tick();
    d_addr = 32'h8; d_wr_data = 32'h3333_3333;
    #1; chk("st2_ready", {31'b0, d_wr_ready}, 32'h1);
    tick();
    d_wr_req = 1'b0;

    // Back-to-back loads with d_rd_req held
    d_rd_req = 1'b1; d_addr = 32'h0;
    #1; chk("ld0_ram_addr", {20'h0, ram_addr}, 32'h0);
    chk("ld0_no_ready", {31'b0, d_rd_ready}, 32'h0);
    tick();
    chk("ld0_ready", {31'b0, d_rd_ready}, 32'h1);
    chk("ld0_data", d_rd_data, 32'h1111_1111);
    d_addr = 32'h4;
    tick();
    chk("ld1_no_ready", {31'b0, d_rd_ready}, 32'h0);
    chk("ld1_ram_cs", {31'b0, ram_cs}, 32'h1);
    chk("ld1_ram_addr", {20'h0, ram_addr}, 32'h1);
    tick();
    chk("ld1_data", d_rd_data, 32'h2222_2222);
    d_addr = 32'h8;
    tick();
    chk("ld2_ram_addr", {20'h0, ram_addr}, 32'h2);
    tick();
    chk("ld2_ready", {31'b0, d_rd_ready}, 32'h1);
    chk("ld2_data", d_rd_data, 32'h3333_3333);
    d_rd_req = 1'b0;
    tick();

    // IO read, ack on the third io_req cycle
    d_addr = 32'h8000_0010; d_rd_req = 1'b1;
    #1; chk("io_rd_no_ram", {31'b0, ram_cs}, 32'h0);
    chk("io_rd_req_n", {31'b0, io_req}, 32'h0);
    tick();
    chk("io_rd_req_c1", {31'b0, io_req}, 32'h1);
    chk("io_rd_addr", {16'h0, io_addr}, 32'h0010);
    chk("io_rd_we", {31'b0, io_we}, 32'h0);
    tick();
    chk("io_rd_req_c2", {31'b0, io_req}, 32'h1);
    tick();
    chk("io_rd_req_c3", {31'b0, io_req}, 32'h1);
    io_ack = 1'b1; io_rdata = 32'h1234_5678;
    tick();
    io_ack = 1'b0; io_rdata = 32'h0;
    chk("io_rd_req_drop", {31'b0, io_req}, 32'h0);
    chk("io_rd_ready", {31'b0, d_rd_ready}, 32'h1);
    chk("io_rd_data", d_rd_data, 32'h1234_5678);
    chk("io_rd_no_err", {31'b0, err_valid}, 32'h0);
    d_rd_req = 1'b0;
    tick();
    chk("io_rd_ready_gone", {31'b0, d_rd_ready}, 32'h0);

    // Fastest IO access: ack at N+1, ready at N+2
    d_addr = 32'h8000_0030; d_rd_req = 1'b1;
    tick();
    io_ack = 1'b1; io_rdata = 32'hFEED_0001;
    tick();
    io_ack = 1'b0;
    chk("io_fast_ready", {31'b0, d_rd_ready}, 32'h1);
    chk("io_fast_data", d_rd_data, 32'hFEED_0001);
    d_rd_req = 1'b0;
    tick();

    // IO write, no ack: timeout after 16 io_req cycles
    d_addr = 32'h8000_0020; d_wr_req = 1'b1; d_be = 4'h3; d_wr_data = 32'h0000_BEEF;
    tick();
    chk("to_we", {31'b0, io_we}, 32'h1);
    chk("to_wdata", io_wdata, 32'h0000_BEEF);
    chk("to_be", {28'h0, io_be}, 32'h3);
    n = 0;
    while (io_req && n < 40) begin
      chk("to_no_ready_wait", {31'b0, d_wr_ready}, 32'h0);
      n++;
      tick();
    end
    chk("to_req_cycles", n, 32'd16);
    chk("to_wr_ready", {31'b0, d_wr_ready}, 32'h1);
    chk("to_err_valid", {31'b0, err_valid}, 32'h1);
    chk("to_err_addr", err_addr, 32'h8000_0020);
    chk("to_no_rd_ready", {31'b0, d_rd_ready}, 32'h0);
    d_wr_req = 1'b0;
    tick();
    chk("to_err_pulse", {31'b0, err_valid}, 32'h0);

    // Ack on the final timeout cycle is a success
    d_addr = 32'h8000_0040; d_rd_req = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("late_ack_req_hi", {31'b0, io_req}, 32'h1);
    io_ack = 1'b1; io_rdata = 32'hA5A5_5A5A;
    tick();
    io_ack = 1'b0;
    chk("late_ack_ready", {31'b0, d_rd_ready}, 32'h1);
    chk("late_ack_data", d_rd_data, 32'hA5A5_5A5A);
    chk("late_ack_no_err", {31'b0, err_valid}, 32'h0);
    chk("late_ack_err_addr", err_addr, 32'h8000_0020);
    d_rd_req = 1'b0;
    tick();

    // Both requests on RAM: read at N+1, write at N+2
    d_addr = 32'h200; d_be = 4'hF; d_wr_data = 32'hCAFE_F00D;
    d_rd_req = 1'b1; d_wr_req = 1'b1;
    #1;
    chk("both_n_no_wr", {31'b0, d_wr_ready}, 32'h0);
    chk("both_n_read", {30'b0, ram_cs, ram_we}, 32'h2);
    tick();
    chk("both_rd_ready", {31'b0, d_rd_ready}, 32'h1);
    chk("both_no_wr_n1", {31'b0, d_wr_ready}, 32'h0);
    d_rd_req = 1'b0;
    tick();
    chk("both_wr_ready", {31'b0, d_wr_ready}, 32'h1);
    chk("both_wr_we", {31'b0, ram_we}, 32'h1);
    d_wr_req = 1'b0;
    tick();

    // Reset during IO_WAIT, late ack ignored
    d_addr = 32'h8000_0050; d_rd_req = 1'b1;
    tick();
    chk("rstmid_req", {31'b0, io_req}, 32'h1);
    rstb = 1'b0; d_rd_req = 1'b0;
    tick();
    chk("rstmid_req_drop", {31'b0, io_req}, 32'h0);
    chk("rstmid_err_addr", err_addr, 32'h0);
    rstb = 1'b1; io_ack = 1'b1; io_rdata = 32'h7777_7777;
    #1;
    chk("rstmid_no_ready_a", {31'b0, d_rd_ready}, 32'h0);
    tick();
    io_ack = 1'b0;
    chk("rstmid_no_ready_b", {31'b0, d_rd_ready}, 32'h0);
    chk("rstmid_no_req", {31'b0, io_req}, 32'h0);
    chk("rstmid_rd_data", d_rd_data, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
